// File: rtl/sif_pkg.sv
// Shared types for the SIF xa host-port initiator: operation codes, FSM states,
// and the default command record with default address/data widths.
package sif_pkg;

  localparam int XA_AW = 16;
  localparam int XA_DW = 16;

  typedef enum logic {
    XA_WRITE = 1'b0,
    XA_READ  = 1'b1
  } xa_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TURN  = 2'd2
  } xa_state_e;

  typedef struct packed {
    xa_op_e             op;
    logic [XA_AW-1:0]   addr;
    logic [XA_DW-1:0]   data;
  } xa_cmd_t;

endpackage

// File: rtl/sif_xa_master_if.sv
// Command, xa bus, response and status bundle for sif_xa_master.
// master = the initiator's view, slave = the source/SIF side.
interface sif_xa_master_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [DW-1:0] xa_data_rd;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          busy;
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, xa_data_rd,
    output cmd_ready, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
           rsp_valid, rsp_addr, rsp_data, busy, wr_count, rd_count
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, xa_data_rd,
    input  cmd_ready, xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
           rsp_valid, rsp_addr, rsp_data, busy, wr_count, rd_count
  );
endinterface

// File: rtl/sif_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head; pointers carry an extra MSB
// so full and empty are distinguished without a separate count.
module sif_cmd_fifo
  import sif_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = xa_cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]    rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    if (pop && !empty)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_q[PW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/sif_xa_master.sv
// SIF xa host-port initiator: queues commands, drives registered xa strobes with
// turnaround gaps on op changes, and returns read data as one-cycle responses.
module sif_xa_master
  import sif_pkg::*;
#(
  parameter int AW         = XA_AW,
  parameter int DW         = XA_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int TURN_GAP   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  sif_xa_master_if.master bus
);
  localparam int            GW       = (TURN_GAP > 1) ? $clog2(TURN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((TURN_GAP > 0) ? TURN_GAP - 1 : 0);

  typedef struct packed {
    xa_op_e        op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          push_cmd, head_cmd;
  logic          push, pop, full, empty, issue;
  xa_state_e     state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  xa_op_e        last_op_q, last_op_d;
  logic [AW-1:0] xa_addr_q, xa_addr_d;
  logic [DW-1:0] xa_data_q, xa_data_d;
  logic          wr_s_q, wr_s_d, rd_s_q, rd_s_d;
  logic          rd_pend_q;
  logic [AW-1:0] rd_addr_q;
  logic          rsp_valid_q;
  logic [AW-1:0] rsp_addr_q;
  logic [DW-1:0] rsp_data_q;
  logic [15:0]   wr_cnt_q, rd_cnt_q;

  assign push     = bus.cmd_valid && !full;
  assign push_cmd = '{op: xa_op_e'(bus.cmd_op), addr: bus.cmd_addr, data: bus.cmd_data};

  sif_cmd_fifo #(.DEPTH(FIFO_DEPTH), .T(cmd_t)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (full),
    .empty     (empty)
  );

  // The bus registers are loaded on the same edge the head is popped, so a
  // command accepted at edge E is on the bus from E+1.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    last_op_d = last_op_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (empty) begin
          state_d = IDLE;
        end else if ((head_cmd.op != last_op_q) && (TURN_GAP > 0)) begin
          state_d = TURN;
          gap_d   = GAP_LOAD;
        end else begin
          issue = 1'b1;
        end
      end
      TURN: begin
        if (gap_q == '0) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    pop       = issue;
    wr_s_d    = issue && (head_cmd.op == XA_WRITE);
    rd_s_d    = issue && (head_cmd.op == XA_READ);
    xa_addr_d = issue ? head_cmd.addr : '0;
    xa_data_d = wr_s_d ? head_cmd.data : '0;
    if (issue) last_op_d = head_cmd.op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      last_op_q   <= XA_WRITE;
      xa_addr_q   <= '0;
      xa_data_q   <= '0;
      wr_s_q      <= 1'b0;
      rd_s_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      last_op_q   <= last_op_d;
      xa_addr_q   <= xa_addr_d;
      xa_data_q   <= xa_data_d;
      wr_s_q      <= wr_s_d;
      rd_s_q      <= rd_s_d;
      // Read pipeline: strobe sampled by the SIF, then its data captured one edge later.
      rd_pend_q   <= rd_s_q;
      rd_addr_q   <= rd_s_q ? xa_addr_q : '0;
      rsp_valid_q <= rd_pend_q;
      rsp_addr_q  <= rd_pend_q ? rd_addr_q : '0;
      rsp_data_q  <= rd_pend_q ? bus.xa_data_rd : '0;
      if (wr_s_d)    wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_pend_q) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.xa_addr    = xa_addr_q;
  assign bus.xa_data_wr = xa_data_q;
  assign bus.xa_wr_s    = wr_s_q;
  assign bus.xa_rd_s    = rd_s_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_addr   = rsp_addr_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = !empty || wr_s_q || rd_s_q || rd_pend_q;
  assign bus.wr_count   = wr_cnt_q;
  assign bus.rd_count   = rd_cnt_q;
endmodule

// File: tb/tb_sif_xa_master.sv
// Directed bench for sif_xa_master: main instance with a 2-cycle turnaround and a
// second instance with a long turnaround used to hold the FSM in TURN while the queue fills.
module tb_sif_xa_master;
  import sif_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sif_xa_master_if #(.AW(16), .DW(16)) bus1 ();
  sif_xa_master_if #(.AW(16), .DW(16)) bus2 ();

  sif_xa_master #(.AW(16), .DW(16), .FIFO_DEPTH(4), .TURN_GAP(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  sif_xa_master #(.AW(16), .DW(16), .FIFO_DEPTH(4), .TURN_GAP(6)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // SIF responder model: read data = addr ^ 0x1214, presented the cycle after the strobe is sampled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              bus1.xa_data_rd <= 16'h0000;
    else if (bus1.xa_rd_s)   bus1.xa_data_rd <= bus1.xa_addr ^ 16'h1214;
  end
  assign bus2.xa_data_rd = 16'hA5A5;

  int          cyc = 0;
  int          both_high = 0;
  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  int          rsp_cyc[$];
  logic [15:0] rsp_addr[$];
  logic [15:0] rsp_data[$];
  logic [15:0] wr2_addr[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus1.xa_rd_s) begin rd_cyc.push_back(cyc); rd_addr.push_back(bus1.xa_addr); end
    if (bus1.xa_wr_s) begin wr_cyc.push_back(cyc); wr_addr.push_back(bus1.xa_addr); end
    if (bus1.rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_addr.push_back(bus1.rsp_addr);
      rsp_data.push_back(bus1.rsp_data);
    end
    if (bus2.xa_wr_s) wr2_addr.push_back(bus2.xa_addr);
    if (bus1.xa_wr_s && bus1.xa_rd_s) both_high = both_high + 1;
    if (bus2.xa_wr_s && bus2.xa_rd_s) both_high = both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic op, input logic [15:0] addr, input logic [15:0] data);
    int w = 0;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_op    = op;
    bus1.cmd_addr  = addr;
    bus1.cmd_data  = data;
    while (!bus1.cmd_ready && w < 50) begin tick(); w++; end
    check("push_ready", {31'd0, bus1.cmd_ready}, 32'd1);
    tick();
    bus1.cmd_valid = 1'b0;
  endtask

  initial begin
    int w;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 1'b0; bus1.cmd_addr = '0; bus1.cmd_data = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_op = 1'b0; bus2.cmd_addr = '0; bus2.cmd_data = '0;

    // Reset state
    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, bus1.cmd_ready}, 32'd1);
    check("rst_flags", {28'd0, bus1.xa_wr_s, bus1.xa_rd_s, bus1.rsp_valid, bus1.busy}, 32'd0);
    check("rst_xa_addr", {16'd0, bus1.xa_addr}, 32'd0);
    check("rst_counts", {bus1.wr_count, bus1.rd_count}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single write
    push1(1'b0, 16'h0010, 16'hBEEF);
    tick();
    check("wr1_strobes", {30'd0, bus1.xa_wr_s, bus1.xa_rd_s}, 32'd2);
    check("wr1_addr", {16'd0, bus1.xa_addr}, 32'h0010);
    check("wr1_data", {16'd0, bus1.xa_data_wr}, 32'hBEEF);
    check("wr1_count", {16'd0, bus1.wr_count}, 32'd1);
    tick();
    check("wr1_strobe_end", {30'd0, bus1.xa_wr_s, bus1.busy}, 32'd0);
    repeat (4) tick();
    check("wr1_no_rsp", rsp_cyc.size(), 32'd0);

    // Single read, 3-edge latency
    push1(1'b1, 16'h0020, 16'hFFFF);
    tick();
    check("rd1_strobes", {30'd0, bus1.xa_wr_s, bus1.xa_rd_s}, 32'd1);
    check("rd1_addr", {16'd0, bus1.xa_addr}, 32'h0020);
    check("rd1_data_wr", {16'd0, bus1.xa_data_wr}, 32'd0);
    tick();
    check("rd1_rsp_early", {31'd0, bus1.rsp_valid}, 32'd0);
    tick();
    check("rd1_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd1);
    check("rd1_rsp_addr", {16'd0, bus1.rsp_addr}, 32'h0020);
    check("rd1_rsp_data", {16'd0, bus1.rsp_data}, 32'h1234);
    check("rd1_count", {16'd0, bus1.rd_count}, 32'd1);
    tick();
    check("rd1_rsp_pulse", {31'd0, bus1.rsp_valid}, 32'd0);
    repeat (2) tick();

    // Four back-to-back reads
    rd_cyc.delete(); rd_addr.delete(); rsp_cyc.delete(); rsp_addr.delete(); rsp_data.delete();
    for (int i = 0; i < 4; i++) push1(1'b1, 16'(i), 16'h0000);
    repeat (6) tick();
    check("rd4_strobe_n", rd_addr.size(), 32'd4);
    check("rd4_rsp_n", rsp_addr.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("rd4_strobe_addr", {16'd0, (i < rd_addr.size()) ? rd_addr[i] : 16'hFFFF}, 32'(i));
      check("rd4_rsp_addr", {16'd0, (i < rsp_addr.size()) ? rsp_addr[i] : 16'hFFFF}, 32'(i));
      check("rd4_rsp_data", {16'd0, (i < rsp_data.size()) ? rsp_data[i] : 16'hFFFF}, 32'h1214 + 32'(i));
    end
    check("rd4_strobe_span", (rd_cyc.size() == 4) ? rd_cyc[3] - rd_cyc[0] : -1, 32'd3);
    check("rd4_rsp_span", (rsp_cyc.size() == 4) ? rsp_cyc[3] - rsp_cyc[0] : -1, 32'd3);
    check("rd4_latency", (rsp_cyc.size() > 0 && rd_cyc.size() > 0) ? rsp_cyc[0] - rd_cyc[0] : -1, 32'd2);
    check("rd4_count", {16'd0, bus1.rd_count}, 32'd5);

    // Write then read with a 2-cycle turnaround
    rd_cyc.delete(); wr_cyc.delete(); rsp_data.delete();
    push1(1'b0, 16'h0040, 16'h5555);
    push1(1'b1, 16'h0041, 16'h0000);
    repeat (8) tick();
    check("turn_wr_n", wr_cyc.size(), 32'd1);
    check("turn_rd_n", rd_cyc.size(), 32'd1);
    check("turn_gap", (wr_cyc.size() == 1 && rd_cyc.size() == 1) ? rd_cyc[0] - wr_cyc[0] - 1 : -1, 32'd2);
    check("turn_rsp_data", {16'd0, (rsp_data.size() > 0) ? rsp_data[0] : 16'hFFFF}, 32'h1255);
    check("turn_wr_count", {16'd0, bus1.wr_count}, 32'd2);

    // Queue fill while the second instance sits in a 6-cycle TURN
    bus2.cmd_valid = 1'b1; bus2.cmd_op = 1'b1; bus2.cmd_addr = 16'h0100; bus2.cmd_data = 16'h0000;
    tick();
    bus2.cmd_op = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus2.cmd_addr = 16'h0200 + 16'(i);
      bus2.cmd_data = 16'hD000 + 16'(i);
      check("fill_ready", {31'd0, bus2.cmd_ready}, 32'd1);
      tick();
    end
    check("fill_full", {31'd0, bus2.cmd_ready}, 32'd0);
    bus2.cmd_addr = 16'h0205;
    bus2.cmd_data = 16'hD005;
    w = 0;
    while (!bus2.cmd_ready && w < 50) begin tick(); w++; end
    check("fill_stall_cycles", w, 32'd4);
    tick();
    bus2.cmd_valid = 1'b0;
    repeat (8) tick();
    check("fill_wr_n", wr2_addr.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check("fill_wr_order", {16'd0, (i < wr2_addr.size()) ? wr2_addr[i] : 16'hFFFF}, 32'h0201 + 32'(i));
    check("fill_counts", {bus2.wr_count, bus2.rd_count}, {16'd5, 16'd1});
    check("fill_idle", {31'd0, bus2.busy}, 32'd0);
    check("never_both_strobes", both_high, 32'd0);

    // Reset while a read is outstanding
    rsp_cyc.delete();
    push1(1'b1, 16'h0050, 16'h0000);
    tick();
    check("rstrd_strobe", {31'd0, bus1.xa_rd_s}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rstrd_flags", {28'd0, bus1.xa_wr_s, bus1.xa_rd_s, bus1.rsp_valid, bus1.busy}, 32'd0);
    check("rstrd_cmd_ready", {31'd0, bus1.cmd_ready}, 32'd1);
    check("rstrd_counts", {bus1.wr_count, bus1.rd_count}, 32'd0);
    check("rstrd_bus", {bus1.xa_addr, bus1.rsp_data}, 32'd0);
    repeat (3) tick();
    check("rstrd_no_rsp", rsp_cyc.size(), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
